risc_mgmt_decode_arbiter: RTL and testbench

- Arbitrates instruction ownership between NUM_EXT RISC-MGMT extensions at the decode stage.
- Broadcasts the decode-stage instruction to every extension and collects their claim and register-select signals.
- Grants the instruction to one extension, routes that extension's register selects to the register file, and stalls decode until the owner reports completion.
- Sits between the decode stage and the per-extension decode interfaces inside RISC-MGMT.

---
 rtl/risc_mgmt_decode_arbiter.sv | 118 +++++++++++
 tb/tb_risc_mgmt_decode_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/risc_mgmt_decode_arbiter.sv
// risc_mgmt_decode_arbiter: grants decode-stage instructions to one RISC-MGMT extension and stalls until it finishes
module risc_mgmt_decode_arbiter #(
  parameter int NUM_EXT = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [31:0]          insn,
  input  logic                 insn_valid,
  input  logic                 flush,
  output logic [31:0]          ext_insn,
  input  logic [NUM_EXT-1:0]   ext_claim,
  input  logic [5*NUM_EXT-1:0] ext_rsel_s_0,
  input  logic [5*NUM_EXT-1:0] ext_rsel_s_1,
  input  logic [5*NUM_EXT-1:0] ext_rsel_d,
  input  logic [NUM_EXT-1:0]   ext_done,
  output logic [NUM_EXT-1:0]   ext_start,
  output logic [NUM_EXT-1:0]   ext_kill,
  output logic                 claimed,
  output logic [2:0]           owner_idx,
  output logic [4:0]           rsel_s_0,
  output logic [4:0]           rsel_s_1,
  output logic [4:0]           rsel_d,
  output logic                 stall,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     conflict_count
);
  localparam int BW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [2:0] owner, win;
  logic [4:0] lat_s0, lat_s1, lat_d, ws0, ws1, wd;
  logic [3:0] ncl;
  logic [BW-1:0] busy_cnt;
  logic [NUM_EXT-1:0] own_mask, start_nxt, kill_nxt;
  logic busy, grant, done_own, tmo_nxt;
  assign ext_insn = insn;
  // lowest-index claimant wins; also count claimants to detect conflicts
  always_comb begin
    win = '0;
    ws0 = '0;
    ws1 = '0;
    wd = '0;
    ncl = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--)
      if (ext_claim[i]) begin
        win = 3'(i);
        ws0 = ext_rsel_s_0[5*i +: 5];
        ws1 = ext_rsel_s_1[5*i +: 5];
        wd = ext_rsel_d[5*i +: 5];
      end
    for (int i = 0; i < NUM_EXT; i++) ncl = ncl + 4'(ext_claim[i]);
  end
  // decode-facing outputs and FSM next state with registered pulse values
  always_comb begin
    busy = state == BUSY;
    claimed = !busy && insn_valid && |ext_claim;
    grant = claimed && !flush;
    stall = busy;
    owner_idx = claimed ? win : owner;
    rsel_s_0 = claimed ? ws0 : busy ? lat_s0 : 5'd0;
    rsel_s_1 = claimed ? ws1 : busy ? lat_s1 : 5'd0;
    rsel_d = claimed ? wd : busy ? lat_d : 5'd0;
    own_mask = NUM_EXT'(1) << owner;
    done_own = |(ext_done & own_mask);
    state_nxt = state;
    start_nxt = '0;
    kill_nxt = '0;
    tmo_nxt = 1'b0;
    if (!busy) begin
      if (grant) begin
        state_nxt = BUSY;
        start_nxt = NUM_EXT'(1) << win;
      end
    end else if (flush) begin
      state_nxt = IDLE;
      kill_nxt = own_mask;
    end else if (done_own) begin
      state_nxt = IDLE;
    end else if (busy_cnt == BW'(TIMEOUT - 1)) begin
      state_nxt = IDLE;
      kill_nxt = own_mask;
      tmo_nxt = 1'b1;
    end
  end
  // state, latched owner context, busy timer and saturating conflict counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      lat_s0 <= '0;
      lat_s1 <= '0;
      lat_d <= '0;
      busy_cnt <= '0;
      ext_start <= '0;
      ext_kill <= '0;
      timeout_err <= 1'b0;
      conflict_count <= '0;
    end else begin
      state <= state_nxt;
      ext_start <= start_nxt;
      ext_kill <= kill_nxt;
      timeout_err <= tmo_nxt;
      if (grant) begin
        owner <= win;
        lat_s0 <= ws0;
        lat_s1 <= ws1;
        lat_d <= wd;
        busy_cnt <= '0;
      end else if (busy) begin
        busy_cnt <= busy_cnt + BW'(1);
      end
      if (!busy && insn_valid && ncl > 4'd1 && conflict_count != '1)
        conflict_count <= conflict_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_risc_mgmt_decode_arbiter.sv
// tb_risc_mgmt_decode_arbiter: directed scenario tests for the decode arbiter
module tb_risc_mgmt_decode_arbiter;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [31:0] insn = '0, ext_insn;
  logic insn_valid = 1'b0, flush = 1'b0;
  logic [3:0] ext_claim = '0, ext_done = '0, ext_start, ext_kill;
  logic [19:0] ext_rsel_s_0 = '0, ext_rsel_s_1 = '0, ext_rsel_d = '0;
  logic claimed, stall, timeout_err;
  logic [2:0] owner_idx;
  logic [4:0] rsel_s_0, rsel_s_1, rsel_d;
  logic [7:0] conflict_count;
  int n_vec = 0, n_err = 0;

  risc_mgmt_decode_arbiter dut (
    .CLK(CLK), .nRST(nRST), .insn(insn), .insn_valid(insn_valid), .flush(flush),
    .ext_insn(ext_insn), .ext_claim(ext_claim), .ext_rsel_s_0(ext_rsel_s_0),
    .ext_rsel_s_1(ext_rsel_s_1), .ext_rsel_d(ext_rsel_d), .ext_done(ext_done),
    .ext_start(ext_start), .ext_kill(ext_kill), .claimed(claimed), .owner_idx(owner_idx),
    .rsel_s_0(rsel_s_0), .rsel_s_1(rsel_s_1), .rsel_d(rsel_d), .stall(stall),
    .timeout_err(timeout_err), .conflict_count(conflict_count)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_sel(input int i, input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d);
    ext_rsel_s_0[5*i +: 5] = s0;
    ext_rsel_s_1[5*i +: 5] = s1;
    ext_rsel_d[5*i +: 5] = d;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    n_vec++; if (ext_start !== 4'b0) begin n_err++; $display("FAIL reset_start got=%b exp=0000", ext_start); end
    n_vec++; if (ext_kill !== 4'b0) begin n_err++; $display("FAIL reset_kill got=%b exp=0000", ext_kill); end
    n_vec++; if (conflict_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", conflict_count); end
    n_vec++; if (owner_idx !== 3'd0) begin n_err++; $display("FAIL reset_owner got=%0d exp=0", owner_idx); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_tmo got=%0b exp=0", timeout_err); end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_grant;
    insn = 32'hDEADBEEF; insn_valid = 1'b1; ext_claim = 4'b0100; set_sel(2, 5'd3, 5'd4, 5'd5);
    #1;
    n_vec++; if (claimed !== 1'b1) begin n_err++; $display("FAIL grant_claimed got=%0b exp=1", claimed); end
    n_vec++; if ({rsel_s_0, rsel_s_1, rsel_d} !== {5'd3, 5'd4, 5'd5}) begin n_err++; $display("FAIL grant_rsel got=%0d/%0d/%0d exp=3/4/5", rsel_s_0, rsel_s_1, rsel_d); end
    n_vec++; if (owner_idx !== 3'd2) begin n_err++; $display("FAIL grant_owner got=%0d exp=2", owner_idx); end
    n_vec++; if (ext_insn !== 32'hDEADBEEF) begin n_err++; $display("FAIL grant_insn got=%h exp=deadbeef", ext_insn); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL grant_idle_stall got=%0b exp=0", stall); end
    step();
    n_vec++; if (ext_start !== 4'b0100) begin n_err++; $display("FAIL grant_start got=%b exp=0100", ext_start); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL grant_stall got=%0b exp=1", stall); end
    n_vec++; if (claimed !== 1'b0) begin n_err++; $display("FAIL grant_busy_claimed got=%0b exp=0", claimed); end
    insn_valid = 1'b0; ext_claim = '0; set_sel(2, 5'd0, 5'd0, 5'd0);
    step();
    n_vec++; if (ext_start !== 4'b0000) begin n_err++; $display("FAIL grant_start_pulse got=%b exp=0000", ext_start); end
    n_vec++; if ({rsel_s_0, rsel_s_1, rsel_d} !== {5'd3, 5'd4, 5'd5}) begin n_err++; $display("FAIL grant_rsel_held got=%0d/%0d/%0d exp=3/4/5", rsel_s_0, rsel_s_1, rsel_d); end
    step();
    step();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL grant_still_busy got=%0b exp=1", stall); end
    ext_done = 4'b0100;
    step();
    ext_done = '0;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL grant_release got=%0b exp=0", stall); end
    n_vec++; if (ext_kill !== 4'b0000) begin n_err++; $display("FAIL grant_nokill got=%b exp=0000", ext_kill); end
  endtask

  task automatic test_conflict;
    insn_valid = 1'b1; ext_claim = 4'b0110; set_sel(1, 5'd1, 5'd2, 5'd6);
    #1;
    n_vec++; if (owner_idx !== 3'd1) begin n_err++; $display("FAIL conf_owner got=%0d exp=1", owner_idx); end
    n_vec++; if (rsel_d !== 5'd6) begin n_err++; $display("FAIL conf_rsel_d got=%0d exp=6", rsel_d); end
    step();
    n_vec++; if (conflict_count !== 8'd1) begin n_err++; $display("FAIL conf_cnt1 got=%0d exp=1", conflict_count); end
    n_vec++; if (ext_start !== 4'b0010) begin n_err++; $display("FAIL conf_start got=%b exp=0010", ext_start); end
    ext_done = 4'b0010;
    step();
    ext_done = '0;
    n_vec++; if (conflict_count !== 8'd1) begin n_err++; $display("FAIL conf_busy_nocount got=%0d exp=1", conflict_count); end
    insn_valid = 1'b0;
    #1;
    n_vec++; if (claimed !== 1'b0) begin n_err++; $display("FAIL conf_novalid_claimed got=%0b exp=0", claimed); end
    step();
    n_vec++; if (stall !== 1'b0 || conflict_count !== 8'd1) begin n_err++; $display("FAIL conf_novalid got=stall%0b/cnt%0d exp=stall0/cnt1", stall, conflict_count); end
    insn_valid = 1'b1; flush = 1'b1;
    for (int k = 0; k < 10; k++) step();
    n_vec++; if (conflict_count !== 8'd11) begin n_err++; $display("FAIL conf_cnt11 got=%0d exp=11", conflict_count); end
    n_vec++; if (stall !== 1'b0 || ext_start !== 4'b0) begin n_err++; $display("FAIL conf_flush_nogrant got=stall%0b/start%b exp=stall0/start0000", stall, ext_start); end
    for (int k = 0; k < 290; k++) step();
    n_vec++; if (conflict_count !== 8'd255) begin n_err++; $display("FAIL conf_sat got=%0d exp=255", conflict_count); end
    insn_valid = 1'b0; flush = 1'b0; ext_claim = '0;
    step();
  endtask

  task automatic test_timeout;
    insn_valid = 1'b1; ext_claim = 4'b0001;
    step();
    insn_valid = 1'b0; ext_claim = '0; ext_done = 4'b1000;
    for (int k = 0; k < 62; k++) step();
    n_vec++; if (stall !== 1'b1 || ext_kill !== 4'b0) begin n_err++; $display("FAIL tmo_cnt62 got=stall%0b/kill%b exp=stall1/kill0000", stall, ext_kill); end
    step();
    n_vec++; if (stall !== 1'b1 || timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_cnt63 got=stall%0b/tmo%0b exp=stall1/tmo0", stall, timeout_err); end
    step();
    n_vec++; if (ext_kill !== 4'b0001 || timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_fire got=kill%b/tmo%0b exp=kill0001/tmo1", ext_kill, timeout_err); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL tmo_idle got=%0b exp=0", stall); end
    ext_done = '0;
    step();
    n_vec++; if (ext_kill !== 4'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse got=kill%b/tmo%0b exp=kill0000/tmo0", ext_kill, timeout_err); end
  endtask

  task automatic test_flush;
    insn_valid = 1'b1; ext_claim = 4'b0010;
    step();
    insn_valid = 1'b0; ext_claim = '0;
    step();
    flush = 1'b1; ext_done = 4'b0010;
    step();
    flush = 1'b0; ext_done = '0;
    n_vec++; if (ext_kill !== 4'b0010) begin n_err++; $display("FAIL flush_kill got=%b exp=0010", ext_kill); end
    n_vec++; if (stall !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL flush_idle got=stall%0b/tmo%0b exp=stall0/tmo0", stall, timeout_err); end
    step();
    n_vec++; if (ext_kill !== 4'b0) begin n_err++; $display("FAIL flush_pulse got=%b exp=0000", ext_kill); end
  endtask

  task automatic test_back_to_back;
    set_sel(3, 5'd7, 5'd8, 5'd9); set_sel(2, 5'd10, 5'd11, 5'd12);
    insn_valid = 1'b1; ext_claim = 4'b1000;
    step();
    n_vec++; if (ext_start !== 4'b1000 || stall !== 1'b1) begin n_err++; $display("FAIL b2b_start got=start%b/stall%0b exp=start1000/stall1", ext_start, stall); end
    ext_done = 4'b1000; ext_claim = 4'b0100;
    #1;
    n_vec++; if (claimed !== 1'b0 || rsel_s_0 !== 5'd7) begin n_err++; $display("FAIL b2b_busy got=claimed%0b/rs0%0d exp=claimed0/rs07", claimed, rsel_s_0); end
    step();
    ext_done = '0;
    n_vec++; if (stall !== 1'b0 || claimed !== 1'b1 || owner_idx !== 3'd2) begin n_err++; $display("FAIL b2b_gap got=stall%0b/claimed%0b/own%0d exp=stall0/claimed1/own2", stall, claimed, owner_idx); end
    n_vec++; if (rsel_s_1 !== 5'd11) begin n_err++; $display("FAIL b2b_rsel got=%0d exp=11", rsel_s_1); end
    step();
    n_vec++; if (ext_start !== 4'b0100 || stall !== 1'b1) begin n_err++; $display("FAIL b2b_regrant got=start%b/stall%0b exp=start0100/stall1", ext_start, stall); end
    insn_valid = 1'b0; ext_claim = '0; ext_done = 4'b0100;
    step();
    ext_done = '0;
  endtask

  task automatic test_async_reset;
    insn_valid = 1'b1; ext_claim = 4'b0001;
    step();
    n_vec++; if (stall !== 1'b1 || conflict_count !== 8'd255) begin n_err++; $display("FAIL arst_pre got=stall%0b/cnt%0d exp=stall1/cnt255", stall, conflict_count); end
    #2 nRST = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0 || ext_start !== 4'b0) begin n_err++; $display("FAIL arst_now got=stall%0b/start%b exp=stall0/start0000", stall, ext_start); end
    n_vec++; if (conflict_count !== 8'd0) begin n_err++; $display("FAIL arst_cnt got=%0d exp=0", conflict_count); end
    insn_valid = 1'b0; ext_claim = '0;
    step();
    nRST = 1'b1;
    step();
    n_vec++; if (stall !== 1'b0 || owner_idx !== 3'd0) begin n_err++; $display("FAIL arst_idle got=stall%0b/own%0d exp=stall0/own0", stall, owner_idx); end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_conflict();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
